tgroup_dispatcher: RTL and testbench

- Upstream of the per-warp ITS/storage stage in the compute unit.
- Accepts thread-group launch requests and assigns each a free thread-group ID.
- Issues one thread-block allocation per cycle whenever a warp is free, tracks per-group block completions, and reports finished groups over a valid/ready interface.

---
 rtl/tgroup_dispatcher.sv | 144 ++++++++++++++
 tb/tb_tgroup_dispatcher.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tgroup_dispatcher.sv
// tgroup_dispatcher: assigns thread-group IDs, issues one block per free warp, reports finished groups.
// Optional TGROUP_DISPATCH_STATS_EN adds stall_cycles_o and groups_launched_o counters.
module tgroup_dispatcher #(
    parameter int PcWidth       = 32,
    parameter int AddressWidth  = 32,
    parameter int TblockIdxBits = 4,
    parameter int TgroupIdBits  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     launch_valid_i,
    output logic                     launch_ready_o,
    input  logic [PcWidth-1:0]       launch_pc_i,
    input  logic [AddressWidth-1:0]  launch_dp_addr_i,
    input  logic [TblockIdxBits:0]   launch_num_blocks_i,
    output logic [TgroupIdBits-1:0]  launch_tgroup_id_o,
    input  logic                     warp_free_i,
    output logic                     allocate_warp_o,
    output logic [PcWidth-1:0]       allocate_pc_o,
    output logic [AddressWidth-1:0]  allocate_dp_addr_o,
    output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
    output logic [TgroupIdBits-1:0]  allocate_tgroup_id_o,
    input  logic                     tblock_done_i,
    input  logic [TgroupIdBits-1:0]  tblock_done_id_i,
    output logic                     tblock_done_ready_o,
    output logic                     group_done_valid_o,
    output logic [TgroupIdBits-1:0]  group_done_id_o,
    input  logic                     group_done_ready_i
`ifdef TGROUP_DISPATCH_STATS_EN
    ,
    output logic [31:0]              stall_cycles_o,
    output logic [31:0]              groups_launched_o
`endif
);
    localparam int NumGroups = 2**TgroupIdBits;
    localparam int CW = TblockIdxBits + 1;

    typedef enum logic {IDLE, DISPATCH} state_e;
    state_e state_q, state_d;

    logic [NumGroups-1:0]     occupied_q, pending_q;
    logic [CW-1:0]            remaining_q [NumGroups];
    logic [PcWidth-1:0]       pc_q;
    logic [AddressWidth-1:0]  dp_q;
    logic [CW-1:0]            num_q;
    logic [TgroupIdBits-1:0]  id_q, free_id, pend_id;
    logic [TblockIdxBits-1:0] idx_q;
    logic launch_fire, last_blk, done_ok, done_fire;

    // Lowest-index free and pending groups
    always_comb begin
        free_id = '0;
        pend_id = '0;
        for (int i = NumGroups - 1; i >= 0; i--) begin
            if (!occupied_q[i]) free_id = TgroupIdBits'(i);
            if (pending_q[i]) pend_id = TgroupIdBits'(i);
        end
    end

    assign launch_fire = launch_valid_i && launch_ready_o;
    assign done_fire   = group_done_valid_o && group_done_ready_i;
    assign last_blk    = ({1'b0, idx_q} + CW'(1)) == num_q;
    assign done_ok     = tblock_done_i && occupied_q[tblock_done_id_i] && remaining_q[tblock_done_id_i] != '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (launch_fire && launch_num_blocks_i != '0 ? DISPATCH : IDLE)
                                  : (allocate_warp_o && last_blk ? IDLE : DISPATCH);
    end

    // All outputs are forced low while reset is held
    always_comb begin
        launch_ready_o        = rst_ni && state_q == IDLE && !(&occupied_q);
        launch_tgroup_id_o    = rst_ni ? free_id : '0;
        allocate_warp_o       = rst_ni && state_q == DISPATCH && warp_free_i;
        allocate_pc_o         = rst_ni ? pc_q : '0;
        allocate_dp_addr_o    = rst_ni ? dp_q : '0;
        allocate_tblock_idx_o = rst_ni ? idx_q : '0;
        allocate_tgroup_id_o  = rst_ni ? id_q : '0;
        tblock_done_ready_o   = 1'b1;
        group_done_valid_o    = rst_ni && |pending_q;
        group_done_id_o       = rst_ni ? pend_id : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q  <= '0;
            dp_q  <= '0;
            num_q <= '0;
            id_q  <= '0;
            idx_q <= '0;
        end else if (launch_fire) begin
            pc_q  <= launch_pc_i;
            dp_q  <= launch_dp_addr_i;
            num_q <= launch_num_blocks_i;
            id_q  <= free_id;
            idx_q <= '0;
        end else if (allocate_warp_o) begin
            idx_q <= idx_q + TblockIdxBits'(1);
        end
    end

    // Launch, completion and done handshake always touch distinct IDs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            occupied_q <= '0;
            pending_q  <= '0;
            for (int i = 0; i < NumGroups; i++) remaining_q[i] <= '0;
        end else begin
            if (launch_fire) begin
                occupied_q[free_id]  <= 1'b1;
                remaining_q[free_id] <= launch_num_blocks_i;
                pending_q[free_id]   <= launch_num_blocks_i == '0;
            end
            if (done_ok) begin
                remaining_q[tblock_done_id_i] <= remaining_q[tblock_done_id_i] - CW'(1);
                if (remaining_q[tblock_done_id_i] == CW'(1)) pending_q[tblock_done_id_i] <= 1'b1;
            end
            if (done_fire) begin
                occupied_q[pend_id] <= 1'b0;
                pending_q[pend_id]  <= 1'b0;
            end
        end
    end

    illegal_done_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        tblock_done_i |-> occupied_q[tblock_done_id_i] && remaining_q[tblock_done_id_i] != '0);

`ifdef TGROUP_DISPATCH_STATS_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cycles_o    <= '0;
            groups_launched_o <= '0;
        end else begin
            if (state_q == DISPATCH && !warp_free_i && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + 32'd1;
            if (launch_fire) groups_launched_o <= groups_launched_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tgroup_dispatcher.sv
// tb_tgroup_dispatcher: table-driven vectors plus directed corner-case sequences.
module tb_tgroup_dispatcher;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        launch_valid_i = 1'b0;
    logic        launch_ready_o;
    logic [31:0] launch_pc_i = '0;
    logic [31:0] launch_dp_addr_i = '0;
    logic [4:0]  launch_num_blocks_i = '0;
    logic [3:0]  launch_tgroup_id_o;
    logic        warp_free_i = 1'b0;
    logic        allocate_warp_o;
    logic [31:0] allocate_pc_o;
    logic [31:0] allocate_dp_addr_o;
    logic [3:0]  allocate_tblock_idx_o;
    logic [3:0]  allocate_tgroup_id_o;
    logic        tblock_done_i = 1'b0;
    logic [3:0]  tblock_done_id_i = '0;
    logic        tblock_done_ready_o;
    logic        group_done_valid_o;
    logic [3:0]  group_done_id_o;
    logic        group_done_ready_i = 1'b0;
`ifdef TGROUP_DISPATCH_STATS_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] groups_launched_o;
`endif

    int tests = 0;
    int fails = 0;

    tgroup_dispatcher dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .launch_valid_i(launch_valid_i), .launch_ready_o(launch_ready_o),
        .launch_pc_i(launch_pc_i), .launch_dp_addr_i(launch_dp_addr_i),
        .launch_num_blocks_i(launch_num_blocks_i), .launch_tgroup_id_o(launch_tgroup_id_o),
        .warp_free_i(warp_free_i), .allocate_warp_o(allocate_warp_o),
        .allocate_pc_o(allocate_pc_o), .allocate_dp_addr_o(allocate_dp_addr_o),
        .allocate_tblock_idx_o(allocate_tblock_idx_o), .allocate_tgroup_id_o(allocate_tgroup_id_o),
        .tblock_done_i(tblock_done_i), .tblock_done_id_i(tblock_done_id_i),
        .tblock_done_ready_o(tblock_done_ready_o),
        .group_done_valid_o(group_done_valid_o), .group_done_id_o(group_done_id_o),
        .group_done_ready_i(group_done_ready_i)
`ifdef TGROUP_DISPATCH_STATS_EN
        , .stall_cycles_o(stall_cycles_o), .groups_launched_o(groups_launched_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic lv; logic [4:0] nb; logic [31:0] pc; logic wf; logic td; logic [3:0] tid; logic gr;
        logic e_lr; logic [3:0] e_lid; logic e_aw; logic [3:0] e_idx; logic [3:0] e_aid;
        logic [31:0] e_pc; logic e_gv; logic [3:0] e_gid;
    } vec_t;

    vec_t tv [24];

    function automatic vec_t mk(input logic lv, input logic [4:0] nb, input logic [31:0] pc, input logic wf,
                                input logic td, input logic [3:0] tid, input logic gr,
                                input logic e_lr, input logic [3:0] e_lid, input logic e_aw, input logic [3:0] e_idx,
                                input logic [3:0] e_aid, input logic [31:0] e_pc, input logic e_gv, input logic [3:0] e_gid);
        vec_t v;
        v.lv = lv; v.nb = nb; v.pc = pc; v.wf = wf; v.td = td; v.tid = tid; v.gr = gr;
        v.e_lr = e_lr; v.e_lid = e_lid; v.e_aw = e_aw; v.e_idx = e_idx; v.e_aid = e_aid;
        v.e_pc = e_pc; v.e_gv = e_gv; v.e_gid = e_gid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        launch_valid_i = 1'b0; launch_num_blocks_i = '0; launch_pc_i = '0; launch_dp_addr_i = '0;
        warp_free_i = 1'b0; tblock_done_i = 1'b0; tblock_done_id_i = '0; group_done_ready_i = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic launch(input logic [4:0] nb, input logic [31:0] pc);
        launch_valid_i = 1'b1; launch_num_blocks_i = nb; launch_pc_i = pc; launch_dp_addr_i = pc << 5;
    endtask

    initial begin
        // lv nb pc wf td tid gr | lr lid aw idx aid pc gv gid
        tv[0]  = mk(1, 3, 'h100, 1, 0, 0, 0,  1, 0, 0, 0, 0, 'h000, 0, 0);
        tv[1]  = mk(0, 0, 0,     1, 0, 0, 0,  0, 1, 1, 0, 0, 'h100, 0, 0);
        tv[2]  = mk(0, 0, 0,     1, 0, 0, 0,  0, 1, 1, 1, 0, 'h100, 0, 0);
        tv[3]  = mk(0, 0, 0,     1, 0, 0, 0,  0, 1, 1, 2, 0, 'h100, 0, 0);
        tv[4]  = mk(0, 0, 0,     1, 1, 0, 0,  1, 1, 0, 3, 0, 'h100, 0, 0);
        tv[5]  = mk(0, 0, 0,     1, 1, 0, 0,  1, 1, 0, 3, 0, 'h100, 0, 0);
        tv[6]  = mk(0, 0, 0,     1, 1, 0, 0,  1, 1, 0, 3, 0, 'h100, 0, 0);
        tv[7]  = mk(0, 0, 0,     1, 0, 0, 1,  1, 1, 0, 3, 0, 'h100, 1, 0);
        tv[8]  = mk(1, 4, 'h200, 0, 0, 0, 0,  1, 0, 0, 3, 0, 'h100, 0, 0);
        tv[9]  = mk(0, 0, 0,     1, 0, 0, 0,  0, 1, 1, 0, 0, 'h200, 0, 0);
        tv[10] = mk(0, 0, 0,     0, 0, 0, 0,  0, 1, 0, 1, 0, 'h200, 0, 0);
        tv[11] = mk(0, 0, 0,     0, 0, 0, 0,  0, 1, 0, 1, 0, 'h200, 0, 0);
        tv[12] = mk(0, 0, 0,     1, 0, 0, 0,  0, 1, 1, 1, 0, 'h200, 0, 0);
        tv[13] = mk(0, 0, 0,     1, 0, 0, 0,  0, 1, 1, 2, 0, 'h200, 0, 0);
        tv[14] = mk(0, 0, 0,     1, 0, 0, 0,  0, 1, 1, 3, 0, 'h200, 0, 0);
        tv[15] = mk(1, 0, 'h300, 1, 0, 0, 0,  1, 1, 0, 4, 0, 'h200, 0, 0);
        tv[16] = mk(0, 0, 0,     1, 0, 0, 0,  1, 2, 0, 0, 1, 'h300, 1, 1);
        tv[17] = mk(0, 0, 0,     1, 0, 0, 1,  1, 2, 0, 0, 1, 'h300, 1, 1);
        tv[18] = mk(0, 0, 0,     1, 1, 0, 0,  1, 1, 0, 0, 1, 'h300, 0, 0);
        tv[19] = mk(0, 0, 0,     1, 1, 0, 0,  1, 1, 0, 0, 1, 'h300, 0, 0);
        tv[20] = mk(0, 0, 0,     1, 1, 0, 0,  1, 1, 0, 0, 1, 'h300, 0, 0);
        tv[21] = mk(0, 0, 0,     1, 1, 0, 0,  1, 1, 0, 0, 1, 'h300, 0, 0);
        tv[22] = mk(0, 0, 0,     1, 0, 0, 1,  1, 1, 0, 0, 1, 'h300, 1, 0);
        tv[23] = mk(0, 0, 0,     0, 0, 0, 0,  1, 0, 0, 0, 1, 'h300, 0, 0);

        // Outputs held low during reset even with requests present
        @(negedge clk_i);
        launch_valid_i = 1'b1; warp_free_i = 1'b1; #1;
        chk("rst_launch_ready", launch_ready_o, 0);
        chk("rst_alloc", allocate_warp_o, 0);
        chk("rst_gdone_valid", group_done_valid_o, 0);
        reset_dut();
        #1;
        chk("post_rst_ready", launch_ready_o, 1);
        chk("post_rst_lid", launch_tgroup_id_o, 0);
        chk("done_ready_tied", tblock_done_ready_o, 1);

        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk_i);
            launch_valid_i = tv[k].lv; launch_num_blocks_i = tv[k].nb;
            launch_pc_i = tv[k].pc; launch_dp_addr_i = tv[k].pc << 5;
            warp_free_i = tv[k].wf; tblock_done_i = tv[k].td; tblock_done_id_i = tv[k].tid;
            group_done_ready_i = tv[k].gr;
            #1;
            chk($sformatf("v%0d_launch_ready", k), launch_ready_o, tv[k].e_lr);
            chk($sformatf("v%0d_launch_id", k), launch_tgroup_id_o, tv[k].e_lid);
            chk($sformatf("v%0d_alloc", k), allocate_warp_o, tv[k].e_aw);
            chk($sformatf("v%0d_idx", k), allocate_tblock_idx_o, tv[k].e_idx);
            chk($sformatf("v%0d_alloc_id", k), allocate_tgroup_id_o, tv[k].e_aid);
            chk($sformatf("v%0d_alloc_pc", k), allocate_pc_o, tv[k].e_pc);
            chk($sformatf("v%0d_gdone_valid", k), group_done_valid_o, tv[k].e_gv);
            if (tv[k].e_gv) chk($sformatf("v%0d_gdone_id", k), group_done_id_o, tv[k].e_gid);
            if (k == 2) chk("v2_alloc_dp", allocate_dp_addr_o, 32'h2000);
        end
`ifdef TGROUP_DISPATCH_STATS_EN
        chk("stall_cycles", stall_cycles_o, 2);
        chk("groups_launched", groups_launched_o, 3);
`endif

        // Saturation: 16 single-block groups, all complete, consumer stalled
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            launch(1, 32'(i)); warp_free_i = 1'b1; #1;
            chk($sformatf("sat_lid%0d", i), launch_tgroup_id_o, i);
            @(negedge clk_i);
            launch_valid_i = 1'b0; #1;
            chk($sformatf("sat_alloc%0d", i), allocate_warp_o, 1);
            @(negedge clk_i);
        end
        #1;
        chk("sat_full_ready", launch_ready_o, 0);
        for (int i = 0; i < 16; i++) begin
            tblock_done_i = 1'b1; tblock_done_id_i = 4'(i);
            @(negedge clk_i);
        end
        tblock_done_i = 1'b0; #1;
        chk("sat_gdone_valid", group_done_valid_o, 1);
        chk("sat_gdone_id", group_done_id_o, 0);
        chk("sat_still_full", launch_ready_o, 0);
        @(negedge clk_i);
        group_done_ready_i = 1'b1; #1;
        chk("sat_gdone_held", group_done_id_o, 0);
        @(negedge clk_i);
        group_done_ready_i = 1'b0; launch(0, 32'h0); #1;
        chk("sat_freed_ready", launch_ready_o, 1);
        chk("sat_freed_lid", launch_tgroup_id_o, 0);
        chk("sat_next_gdone", group_done_id_o, 1);
        @(negedge clk_i);
        launch_valid_i = 1'b0; #1;
        chk("sat_relaunch_full", launch_ready_o, 0);

        // Simultaneous launch, last completion and done handshake
        reset_dut();
        warp_free_i = 1'b1; launch(1, 32'h10); #1;
        chk("sim_lid0", launch_tgroup_id_o, 0);
        @(negedge clk_i);
        launch_valid_i = 1'b0;
        @(negedge clk_i);
        launch(0, 32'h18); #1;
        chk("sim_lid1", launch_tgroup_id_o, 1);
        @(negedge clk_i);
        launch(2, 32'h20); tblock_done_i = 1'b1; tblock_done_id_i = 4'd0; group_done_ready_i = 1'b1; #1;
        chk("sim_pend_id", group_done_id_o, 1);
        chk("sim_lid2", launch_tgroup_id_o, 2);
        chk("sim_ready", launch_ready_o, 1);
        @(negedge clk_i);
        launch_valid_i = 1'b0; tblock_done_i = 1'b0; #1;
        chk("sim_g0_valid", group_done_valid_o, 1);
        chk("sim_g0_id", group_done_id_o, 0);
        chk("sim_alloc", allocate_warp_o, 1);
        chk("sim_alloc_id", allocate_tgroup_id_o, 2);
        chk("sim_alloc_pc", allocate_pc_o, 32'h20);
        chk("sim_free_lid", launch_tgroup_id_o, 1);
        @(negedge clk_i);
        group_done_ready_i = 1'b0; #1;
        chk("sim_cleared", group_done_valid_o, 0);
        chk("sim_idx1", allocate_tblock_idx_o, 1);

        // Reset in the middle of a 4-block dispatch
        reset_dut();
        warp_free_i = 1'b1; launch(4, 32'h40);
        @(negedge clk_i);
        launch_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("mid_idx2", allocate_tblock_idx_o, 2);
        rst_ni = 1'b0; #1;
        chk("mid_rst_alloc", allocate_warp_o, 0);
        chk("mid_rst_pc", allocate_pc_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1; #1;
        chk("mid_post_ready", launch_ready_o, 1);
        chk("mid_post_alloc", allocate_warp_o, 0);
        chk("mid_post_lid", launch_tgroup_id_o, 0);
        @(negedge clk_i);
        #1;
        chk("mid_still_idle", allocate_warp_o, 0);
        launch(1, 32'h50);
        @(negedge clk_i);
        launch_valid_i = 1'b0; #1;
        chk("mid_relaunch_alloc", allocate_warp_o, 1);
        chk("mid_relaunch_id", allocate_tgroup_id_o, 0);
        chk("mid_relaunch_pc", allocate_pc_o, 32'h50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
